// File: rtl/carousel_drain_arbiter_pkg.sv
// Shared carousel types: the slot-index type and the valid/data entry used
// for the drain arbiter's single output register.
package carousel_drain_arbiter_pkg;

    localparam int CAROUSEL_WIDTH  = 8;
    localparam int CAROUSEL_SLOTS  = 3;

    function automatic int lane_width(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    localparam int CAROUSEL_LANE_W = lane_width(CAROUSEL_SLOTS);

    typedef logic [CAROUSEL_LANE_W-1:0] lane_idx_t;

    typedef struct packed {
        logic                      valid;
        logic [CAROUSEL_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/carousel_drain_arbiter_if.sv
// Per-slot input handshakes plus the merged output stream of the drain arbiter.
interface carousel_drain_arbiter_if
    import carousel_drain_arbiter_pkg::*;
#(
    parameter int WIDTH       = CAROUSEL_WIDTH,
    parameter int BUFFER_SIZE = CAROUSEL_SLOTS,
    parameter int LANE_W      = CAROUSEL_LANE_W,
    parameter int COUNT_W     = 16
);
    logic [WIDTH-1:0]       data_in [BUFFER_SIZE];
    logic [BUFFER_SIZE-1:0] data_in_valid;
    logic [BUFFER_SIZE-1:0] data_in_ready;
    logic [WIDTH-1:0]       data_out;
    logic [LANE_W-1:0]      data_out_lane;
    logic                   data_out_valid;
    logic                   data_out_ready;
    logic [COUNT_W-1:0]     drain_count;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_lane, data_out_valid, drain_count
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_lane, data_out_valid, drain_count
    );
endinterface

// File: rtl/carousel_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// The pointer register lives in the caller so upstream and downstream users share it.
module carousel_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);
    int          slot;
    logic [PW-1:0] idx;

    // NOTE: every output gets a default at the top of always_comb so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        slot      = 0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            slot = int'(ptr) + k;
            if (slot >= N) slot = slot - N;
            idx = PW'(slot);
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
        any = any && en;
        if (any) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/carousel_drain_arbiter.sv
// Merges the carousel's per-slot handshakes into one registered stream, tagging
// each word with its slot index; round-robin fair, one word per cycle.
module carousel_drain_arbiter
    import carousel_drain_arbiter_pkg::*;
#(
    parameter int WIDTH       = CAROUSEL_WIDTH,
    parameter int BUFFER_SIZE = CAROUSEL_SLOTS,
    parameter int COUNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    carousel_drain_arbiter_if.slave  bus
);
    localparam int LANE_W = lane_width(BUFFER_SIZE);

    entry_t             out_q;
    lane_idx_t          out_lane;
    lane_idx_t          rr_ptr;
    logic [COUNT_W-1:0] drain_count;

    logic               can_load;
    logic               out_fire;
    logic [BUFFER_SIZE-1:0] grant;
    lane_idx_t          grant_idx;
    logic               grant_any;
    logic [WIDTH-1:0]   grant_data;

    assign can_load   = !out_q.valid || bus.data_out_ready;
    assign out_fire   = out_q.valid && bus.data_out_ready;
    assign grant_data = bus.data_in[grant_idx];

    // Gating with rst keeps every slot's ready low while reset is held.
    carousel_rr_arbiter #(
        .N  (BUFFER_SIZE),
        .PW (LANE_W)
    ) u_rr (
        .req       (bus.data_in_valid),
        .ptr       (rr_ptr),
        .en        (can_load && !rst),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data register is reset too, since data_out must read 0 in reset.
            out_q       <= '0;
            out_lane    <= '0;
            rr_ptr      <= '0;
            drain_count <= '0;
        end else begin
            if (out_fire) drain_count <= drain_count + COUNT_W'(1);
            if (grant_any) begin
                out_q.valid <= 1'b1;
                out_q.data  <= grant_data;
                out_lane    <= grant_idx;
                rr_ptr      <= (grant_idx == lane_idx_t'(BUFFER_SIZE - 1))
                               ? '0 : lane_idx_t'(grant_idx + 1'b1);
            end else if (bus.data_out_ready) begin
                out_q.valid <= 1'b0;
            end
        end
    end

    assign bus.data_in_ready  = grant;
    assign bus.data_out       = out_q.data;
    assign bus.data_out_lane  = out_lane;
    assign bus.data_out_valid = out_q.valid;
    assign bus.drain_count    = drain_count;

endmodule
